// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the RAM 64-bit rw port.
// One registered transaction at a time: ACCESS, WAIT, RESP.
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [63:0] rw_addr,
  output logic [63:0] rw_data_in,
  output logic        rw_write_en,
  input  logic [63:0] rw_data_out,
  input  logic        rw_error,
  output logic [31:0] cnt0,
  output logic [31:0] cnt1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [64:0] LIMIT = 65'(MEM_BYTES);

  logic [1:0]  state;
  logic        last;
  logic        id;
  logic        inb;

  logic        any;
  logic        sample;
  logic        win;
  logic [63:0] win_addr;
  logic [63:0] win_wdata;
  logic        win_we;
  logic        win_inb;
  logic [64:0] win_end;

  // RESP exit doubles as the next arbitration point
  assign sample    = (state == IDLE) || (state == RESP);
  assign any       = req0 | req1;
  assign win       = (req0 & req1) ? ~last : req1;
  assign win_addr  = win ? addr1 : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign win_we    = win ? we1 : we0;
  assign win_end   = {1'b0, win_addr} + 65'd7;
  assign win_inb   = win_end < LIMIT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      id          <= 1'b0;
      inb         <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rw_write_en <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      rdata       <= '0;
      rw_addr     <= '0;
      rw_data_in  <= '0;
      cnt0        <= '0;
      cnt1        <= '0;
    end else begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rw_write_en <= 1'b0;
      unique case (state)
        ACCESS: state <= WAIT;
        WAIT: begin
          state <= RESP;
          rdata <= rw_data_out;
          err   <= rw_error | ~inb;
          done0 <= ~id;
          done1 <= id;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (sample && any) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            id          <= win;
            last        <= win;
            inb         <= win_inb;
            rw_addr     <= win_addr;
            rw_data_in  <= win_wdata;
            rw_write_en <= win_we & win_inb;
            gnt0        <= ~win;
            gnt1        <= win;
            if (!win && cnt0 != '1) cnt0 <= cnt0 + 32'd1;
            if (win && cnt1 != '1) cnt1 <= cnt1 + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, vector table,
// plus contention, held-request and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err, busy, rw_write_en;
  logic [63:0] rdata, rw_addr, rw_data_in;
  logic [63:0] rw_data_out = '0;
  logic        rw_error = 1'b0;
  logic [31:0] cnt0, cnt1;
  logic        inj = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int wen_cnt = 0;

  logic [63:0] mem [logic [63:0]];

  mem_port_arbiter #(.MEM_BYTES(524288)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .busy(busy),
    .rw_addr(rw_addr), .rw_data_in(rw_data_in),
    .rw_write_en(rw_write_en),
    .rw_data_out(rw_data_out), .rw_error(rw_error),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data and error one cycle after the address
  always @(posedge clk) begin
    rw_data_out <= mem.exists(rw_addr) ? mem[rw_addr] : 64'd0;
    rw_error    <= inj;
    if (rw_write_en) mem[rw_addr] = rw_data_in;
  end

  always @(negedge clk) if (rw_write_en) wen_cnt++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"},
          64'({gnt0, gnt1, done0, done1, rw_write_en, err, busy}), 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rw_addr"}, rw_addr, 0);
    check({tag, "_rw_din"}, rw_data_in, 0);
    check({tag, "_cnts"}, {cnt0, cnt1}, 0);
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; inj = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [63:0] a0, a1, d0, d1;
    logic        inj;
    int          port;
    logic        chk_rd;
    logic [63:0] rd;
    logic        er;
    int          wen;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int lat, port, dport, w_start;
    logic got;
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    inj = v.inj;
    w_start = wen_cnt;
    lat = 0; got = 0; port = -1; dport = -1;
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (gnt0 | gnt1) begin got = 1; port = gnt1 ? 1 : 0; end
    end
    check($sformatf("v%0d_gnt_lat", idx), 64'(lat), 1);
    check($sformatf("v%0d_gnt_port", idx), 64'(port), 64'(v.port));
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (done0 | done1) begin got = 1; dport = done1 ? 1 : 0; end
    end
    check($sformatf("v%0d_done_lat", idx), 64'(lat), 3);
    check($sformatf("v%0d_done_port", idx), 64'(dport), 64'(v.port));
    if (v.chk_rd) check($sformatf("v%0d_rdata", idx), rdata, v.rd);
    check($sformatf("v%0d_err", idx), 64'(err), 64'(v.er));
    check($sformatf("v%0d_wen", idx), 64'(wen_cnt - w_start), 64'(v.wen));
    req0 = 0; req1 = 0; inj = 0;
    @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    logic [5:0] g, d;
    logic [3:0] ord;
    int n, k;
    logic dn;

    tbl[0] = '{1, 0, 0, 0, 64'h100, 0, 0, 0, 0,
               0, 1, 64'hDEAD_BEEF_0000_0001, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 0, 64'h200, 0, 64'h1234, 0,
               1, 0, 0, 0, 1};
    tbl[2] = '{0, 1, 0, 0, 0, 64'h200, 0, 0, 0,
               1, 1, 64'h1234, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 64'h7FFF9, 0, 64'hAAAA, 0, 0,
               0, 0, 0, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0,
               1, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 0, 0, 64'h7FFF8, 0, 0, 0, 0,
               0, 1, 64'd0, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 64'h100, 64'h200, 0, 0, 0,
               1, 1, 64'h1234, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 64'h100, 0, 0, 0, 1,
               0, 1, 64'hDEAD_BEEF_0000_0001, 1, 0};

    mem[64'h100] = 64'hDEAD_BEEF_0000_0001;

    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);
    check("tbl_cnt0", 64'(cnt0), 4);
    check("tbl_cnt1", 64'(cnt1), 4);
    check("tbl_busy", 64'(busy), 0);

    // Held request: re-granted on the edge that leaves RESP
    do_reset();
    req0 = 1; we0 = 0; addr0 = 64'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g[c] = gnt0;
      d[c] = done0;
    end
    req0 = 0;
    @(negedge clk);
    check("held_gnt", 64'(g), 64'(6'b001001));
    check("held_done", 64'(d), 64'(6'b100100));
    check("held_cnt0", 64'(cnt0), 2);

    // Contention: both held, round robin from port 0
    do_reset();
    req0 = 1; we0 = 0; addr0 = 64'h100;
    req1 = 1; we1 = 0; addr1 = 64'h200;
    n = 0; k = 0; ord = '0;
    while (n < 4 && k < 30) begin
      @(negedge clk); k++;
      if (gnt0 | gnt1) begin ord[n] = gnt1; n++; end
    end
    req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);
    check("rr_count", 64'(n), 4);
    check("rr_order", 64'(ord), 64'(4'b1010));
    check("rr_cnt0", 64'(cnt0), 2);
    check("rr_cnt1", 64'(cnt1), 2);
    check("rr_busy", 64'(busy), 0);

    // Reset while in WAIT aborts without done
    req0 = 1; we0 = 1; addr0 = 64'h300; wdata0 = 64'h55;
    @(negedge clk);
    check("ab_gnt", 64'({gnt0, gnt1}), 64'(2'b10));
    @(negedge clk);
    check("ab_busy", 64'(busy), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("ab");
    req0 = 0; req1 = 1; we1 = 0; addr1 = 64'h300;
    dn = 0;
    @(negedge clk); dn |= done0 | done1;
    @(negedge clk); dn |= done0 | done1;
    reset = 1'b0;
    check("ab_no_done", 64'(dn), 0);
    @(negedge clk);
    check("ab_first_gnt", 64'({gnt0, gnt1}), 64'(2'b01));
    repeat (2) @(negedge clk);
    check("ab_done1", 64'(done1), 1);
    check("ab_rdata", rdata, 64'h55);
    req1 = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
